// File: rtl/ras_ckpt_pkg.sv
// Shared types for the return-address stack.
//   RAS_DEPTH   : default number of stack entries
//   word_t      : 32-bit address word
//   ras_state_t : one stack copy (entries, top pointer, occupancy) at the default sizes
//   ras_op_t    : resolved per-cycle stack operation
//   decode_op   : maps (push, pop, empty) onto a ras_op_t
package ras_ckpt_pkg;

   localparam int unsigned RAS_DEPTH = 8;

   typedef logic [31:0] word_t;

   typedef struct packed {
      word_t [RAS_DEPTH-1:0]          entries;
      logic [$clog2(RAS_DEPTH)-1:0]   ptr;
      logic [$clog2(RAS_DEPTH):0]     cnt;
   } ras_state_t;

   typedef enum logic [1:0] {
      OP_HOLD,
      OP_PUSH,
      OP_POP,
      OP_REPL
   } ras_op_t;

   // Push+pop on an empty stack degrades to a plain push; a pop on an
   // empty stack is dropped.
   function automatic ras_op_t decode_op(input logic push, input logic pop,
                                         input logic empty);
      if (push && pop && !empty) return OP_REPL;
      if (push)                  return OP_PUSH;
      if (pop && !empty)         return OP_POP;
      return OP_HOLD;
   endfunction

endpackage

// File: rtl/ras_ckpt_core.sv
// One copy of the return-address stack.
//   clk, reset        : clock, asynchronous active-low reset
//   push, pop, addr   : stack operation for this cycle
//   load, load_*      : when load=1, next state is taken from load_* instead
//   ents, ptr, cnt    : current registered state
//   next_*            : combinational next state (used to checkpoint-restore the other copy)
module ras_core
   import ras_ckpt_pkg::*;
#(
   parameter int unsigned DEPTH = RAS_DEPTH,
   parameter int unsigned AW    = 32,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  logic [AW-1:0]                addr,
   input  logic                         load,
   input  logic [DEPTH-1:0][AW-1:0]     load_ents,
   input  logic [PTR_W-1:0]             load_ptr,
   input  logic [PTR_W:0]               load_cnt,
   output logic [DEPTH-1:0][AW-1:0]     ents,
   output logic [PTR_W-1:0]             ptr,
   output logic [PTR_W:0]               cnt,
   output logic [DEPTH-1:0][AW-1:0]     next_ents,
   output logic [PTR_W-1:0]             next_ptr,
   output logic [PTR_W:0]               next_cnt
);

   localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

   logic [PTR_W-1:0] ptr_inc;
   logic [PTR_W-1:0] ptr_dec;
   ras_op_t          op;

   assign ptr_inc = ptr + 1'b1;
   assign ptr_dec = ptr - 1'b1;
   assign op      = decode_op(push, pop, (cnt == '0));

   always_comb begin
      next_ents = ents;
      next_ptr  = ptr;
      next_cnt  = cnt;
      if (load) begin
         next_ents = load_ents;
         next_ptr  = load_ptr;
         next_cnt  = load_cnt;
      end else begin
         unique case (op)
            OP_PUSH: begin
               // On a full stack the slot at ptr+1 is the oldest entry.
               next_ptr           = ptr_inc;
               next_ents[ptr_inc] = addr;
               if (cnt != CNT_FULL) next_cnt = cnt + 1'b1;
            end
            OP_POP: begin
               next_ptr = ptr_dec;
               next_cnt = cnt - 1'b1;
            end
            OP_REPL: next_ents[ptr] = addr;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ents <= '0;
         ptr  <= '0;
         cnt  <= '0;
      end else begin
         ents <= next_ents;
         ptr  <= next_ptr;
         cnt  <= next_cnt;
      end
   end

endmodule

// File: rtl/ras_ckpt.sv
// Checkpointed return-address stack: a speculative copy driven by fetch
// predictions and a committed copy driven by retirement. A flush reloads the
// speculative copy from the committed copy's next state in one cycle.
//   clk, reset                     : clock, asynchronous active-low reset
//   spec_push, spec_pop, spec_addr : predicted call/return from fetch
//   cmt_push, cmt_pop, cmt_addr    : retiring call/return
//   flush                          : mispredict recovery
//   top_valid, top_addr            : predicted jr target and its validity
//   spec_ptr, spec_cnt, cmt_cnt    : debug / checkpoint tagging
module ras_ckpt
   import ras_ckpt_pkg::*;
#(
   parameter int unsigned DEPTH = RAS_DEPTH,
   parameter int unsigned AW    = 32,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             spec_push,
   input  logic             spec_pop,
   input  logic [AW-1:0]    spec_addr,
   input  logic             cmt_push,
   input  logic             cmt_pop,
   input  logic [AW-1:0]    cmt_addr,
   input  logic             flush,
   output logic             top_valid,
   output logic [AW-1:0]    top_addr,
   output logic [PTR_W-1:0] spec_ptr,
   output logic [PTR_W:0]   spec_cnt,
   output logic [PTR_W:0]   cmt_cnt
);

   logic [DEPTH-1:0][AW-1:0] cmt_ents, cmt_next_ents;
   logic [PTR_W-1:0]         cmt_ptr,  cmt_next_ptr;
   logic [PTR_W:0]           cmt_next_cnt;

   logic [DEPTH-1:0][AW-1:0] spec_ents, spec_next_ents;
   logic [PTR_W-1:0]         spec_next_ptr;
   logic [PTR_W:0]           spec_next_cnt;

   ras_core #(.DEPTH(DEPTH), .AW(AW)) u_cmt (
      .clk       (clk),
      .reset     (reset),
      .push      (cmt_push),
      .pop       (cmt_pop),
      .addr      (cmt_addr),
      .load      (1'b0),
      .load_ents ('0),
      .load_ptr  ('0),
      .load_cnt  ('0),
      .ents      (cmt_ents),
      .ptr       (cmt_ptr),
      .cnt       (cmt_cnt),
      .next_ents (cmt_next_ents),
      .next_ptr  (cmt_next_ptr),
      .next_cnt  (cmt_next_cnt)
   );

   // Restoring from the committed next state folds a same-cycle retirement
   // into the recovered speculative stack.
   ras_core #(.DEPTH(DEPTH), .AW(AW)) u_spec (
      .clk       (clk),
      .reset     (reset),
      .push      (spec_push),
      .pop       (spec_pop),
      .addr      (spec_addr),
      .load      (flush),
      .load_ents (cmt_next_ents),
      .load_ptr  (cmt_next_ptr),
      .load_cnt  (cmt_next_cnt),
      .ents      (spec_ents),
      .ptr       (spec_ptr),
      .cnt       (spec_cnt),
      .next_ents (spec_next_ents),
      .next_ptr  (spec_next_ptr),
      .next_cnt  (spec_next_cnt)
   );

   assign top_valid = (spec_cnt != '0);
   assign top_addr  = spec_ents[spec_ptr];

endmodule

// File: tb/tb_ras_ckpt.sv
module tb_ras_ckpt;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        spec_push = 1'b0, spec_pop = 1'b0;
   logic [31:0] spec_addr = '0;
   logic        cmt_push = 1'b0, cmt_pop = 1'b0;
   logic [31:0] cmt_addr = '0;
   logic        flush = 1'b0;
   logic        top_valid;
   logic [31:0] top_addr;
   logic [2:0]  spec_ptr;
   logic [3:0]  spec_cnt;
   logic [3:0]  cmt_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ras_ckpt #(.DEPTH(8), .AW(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .spec_push (spec_push),
      .spec_pop  (spec_pop),
      .spec_addr (spec_addr),
      .cmt_push  (cmt_push),
      .cmt_pop   (cmt_pop),
      .cmt_addr  (cmt_addr),
      .flush     (flush),
      .top_valid (top_valid),
      .top_addr  (top_addr),
      .spec_ptr  (spec_ptr),
      .spec_cnt  (spec_cnt),
      .cmt_cnt   (cmt_cnt)
   );

   // Apply one cycle of stimulus; returns 1 time unit after the capturing edge.
   task automatic step(input logic sp, input logic spo, input logic [31:0] sa,
                       input logic cp, input logic cpo, input logic [31:0] ca,
                       input logic fl);
      spec_push = sp; spec_pop = spo; spec_addr = sa;
      cmt_push = cp;  cmt_pop = cpo;  cmt_addr = ca;
      flush = fl;
      @(posedge clk);
      #1;
      spec_push = 1'b0; spec_pop = 1'b0; spec_addr = '0;
      cmt_push = 1'b0;  cmt_pop = 1'b0;  cmt_addr = '0;
      flush = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++; if (top_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", top_valid); end
      n_tests++; if (top_addr !== 32'h0) begin n_fail++; $display("FAIL reset_top: got %h want 0", top_addr); end
      n_tests++; if (spec_ptr !== 3'd0) begin n_fail++; $display("FAIL reset_ptr: got %0d want 0", spec_ptr); end
      n_tests++; if (spec_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_scnt: got %0d want 0", spec_cnt); end
      n_tests++; if (cmt_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_ccnt: got %0d want 0", cmt_cnt); end
   endtask

   task automatic test_push_pop();
      do_reset();
      step(1, 0, 32'h100, 0, 0, 0, 0);
      n_tests++; if (top_addr !== 32'h100) begin n_fail++; $display("FAIL push1_top: got %h want 100", top_addr); end
      step(1, 0, 32'h200, 0, 0, 0, 0);
      step(1, 0, 32'h300, 0, 0, 0, 0);
      n_tests++; if (top_addr !== 32'h300) begin n_fail++; $display("FAIL push3_top: got %h want 300", top_addr); end
      n_tests++; if (spec_cnt !== 4'd3) begin n_fail++; $display("FAIL push3_cnt: got %0d want 3", spec_cnt); end
      n_tests++; if (spec_ptr !== 3'd3) begin n_fail++; $display("FAIL push3_ptr: got %0d want 3", spec_ptr); end
      n_tests++; if (cmt_cnt !== 4'd0) begin n_fail++; $display("FAIL push3_ccnt: got %0d want 0", cmt_cnt); end
      step(0, 1, 0, 0, 0, 0, 0);
      n_tests++; if (top_addr !== 32'h200) begin n_fail++; $display("FAIL pop_top: got %h want 200", top_addr); end
      n_tests++; if (spec_cnt !== 4'd2) begin n_fail++; $display("FAIL pop_cnt: got %0d want 2", spec_cnt); end
   endtask

   task automatic test_overflow();
      logic [31:0] last_top;
      do_reset();
      for (int i = 1; i <= 9; i++) step(1, 0, 32'(i * 16), 0, 0, 0, 0);
      n_tests++; if (spec_cnt !== 4'd8) begin n_fail++; $display("FAIL ovf_cnt: got %0d want 8", spec_cnt); end
      n_tests++; if (top_addr !== 32'h90) begin n_fail++; $display("FAIL ovf_top: got %h want 90", top_addr); end
      n_tests++; if (spec_ptr !== 3'd1) begin n_fail++; $display("FAIL ovf_ptr: got %0d want 1", spec_ptr); end
      last_top = '0;
      for (int i = 0; i < 8; i++) begin
         if (top_valid) last_top = top_addr;
         step(0, 1, 0, 0, 0, 0, 0);
      end
      n_tests++; if (last_top !== 32'h20) begin n_fail++; $display("FAIL ovf_last_top: got %h want 20", last_top); end
      n_tests++; if (spec_cnt !== 4'd0) begin n_fail++; $display("FAIL ovf_empty_cnt: got %0d want 0", spec_cnt); end
      n_tests++; if (top_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty_valid: got %b want 0", top_valid); end
      n_tests++; if (spec_ptr !== 3'd1) begin n_fail++; $display("FAIL ovf_empty_ptr: got %0d want 1", spec_ptr); end
      // popped entries are not cleared: slot 1 still holds 0x90
      n_tests++; if (top_addr !== 32'h90) begin n_fail++; $display("FAIL ovf_stale_top: got %h want 90", top_addr); end
      step(0, 1, 0, 0, 0, 0, 0);
      n_tests++; if (spec_ptr !== 3'd1) begin n_fail++; $display("FAIL underflow_ptr: got %0d want 1", spec_ptr); end
      n_tests++; if (spec_cnt !== 4'd0) begin n_fail++; $display("FAIL underflow_cnt: got %0d want 0", spec_cnt); end
   endtask

   task automatic test_push_and_pop();
      do_reset();
      step(1, 0, 32'hA0, 0, 0, 0, 0);
      step(1, 1, 32'hB0, 0, 0, 0, 0);
      n_tests++; if (top_addr !== 32'hB0) begin n_fail++; $display("FAIL repl_top: got %h want b0", top_addr); end
      n_tests++; if (spec_cnt !== 4'd1) begin n_fail++; $display("FAIL repl_cnt: got %0d want 1", spec_cnt); end
      n_tests++; if (spec_ptr !== 3'd1) begin n_fail++; $display("FAIL repl_ptr: got %0d want 1", spec_ptr); end
      do_reset();
      step(1, 1, 32'hC0, 0, 0, 0, 0);
      n_tests++; if (spec_cnt !== 4'd1) begin n_fail++; $display("FAIL empty_pp_cnt: got %0d want 1", spec_cnt); end
      n_tests++; if (top_addr !== 32'hC0) begin n_fail++; $display("FAIL empty_pp_top: got %h want c0", top_addr); end
      n_tests++; if (spec_ptr !== 3'd1) begin n_fail++; $display("FAIL empty_pp_ptr: got %0d want 1", spec_ptr); end
   endtask

   task automatic test_flush();
      do_reset();
      step(1, 0, 32'h500, 1, 0, 32'h400, 0);
      step(1, 0, 32'h600, 0, 0, 0, 0);
      n_tests++; if (top_addr !== 32'h600) begin n_fail++; $display("FAIL preflush_top: got %h want 600", top_addr); end
      n_tests++; if (spec_cnt !== 4'd2) begin n_fail++; $display("FAIL preflush_cnt: got %0d want 2", spec_cnt); end
      n_tests++; if (cmt_cnt !== 4'd1) begin n_fail++; $display("FAIL preflush_ccnt: got %0d want 1", cmt_cnt); end
      step(0, 0, 0, 0, 0, 0, 1);
      n_tests++; if (top_addr !== 32'h400) begin n_fail++; $display("FAIL flush_top: got %h want 400", top_addr); end
      n_tests++; if (spec_cnt !== 4'd1) begin n_fail++; $display("FAIL flush_cnt: got %0d want 1", spec_cnt); end
      n_tests++; if (spec_ptr !== 3'd1) begin n_fail++; $display("FAIL flush_ptr: got %0d want 1", spec_ptr); end
      n_tests++; if (cmt_cnt !== 4'd1) begin n_fail++; $display("FAIL flush_ccnt: got %0d want 1", cmt_cnt); end
   endtask

   // Continues from the state left by test_flush (committed: ptr 1, {0x400}).
   task automatic test_flush_same_cycle();
      step(1, 0, 32'h800, 1, 0, 32'h700, 1);
      n_tests++; if (top_addr !== 32'h700) begin n_fail++; $display("FAIL flushret_top: got %h want 700", top_addr); end
      n_tests++; if (spec_cnt !== 4'd2) begin n_fail++; $display("FAIL flushret_cnt: got %0d want 2", spec_cnt); end
      n_tests++; if (spec_ptr !== 3'd2) begin n_fail++; $display("FAIL flushret_ptr: got %0d want 2", spec_ptr); end
      n_tests++; if (cmt_cnt !== 4'd2) begin n_fail++; $display("FAIL flushret_ccnt: got %0d want 2", cmt_cnt); end
      step(0, 1, 0, 0, 0, 0, 0);
      n_tests++; if (top_addr !== 32'h400) begin n_fail++; $display("FAIL flushret_pop_top: got %h want 400", top_addr); end
      n_tests++; if (spec_cnt !== 4'd1) begin n_fail++; $display("FAIL flushret_pop_cnt: got %0d want 1", spec_cnt); end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 1; i <= 5; i++) step(1, 0, 32'(i), 1, 0, 32'(i), 0);
      n_tests++; if (spec_cnt !== 4'd5) begin n_fail++; $display("FAIL ar_pre_cnt: got %0d want 5", spec_cnt); end
      #2;
      reset = 1'b0;
      #1;
      n_tests++; if (top_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b want 0", top_valid); end
      n_tests++; if (top_addr !== 32'h0) begin n_fail++; $display("FAIL ar_top: got %h want 0", top_addr); end
      n_tests++; if (spec_ptr !== 3'd0) begin n_fail++; $display("FAIL ar_ptr: got %0d want 0", spec_ptr); end
      n_tests++; if (spec_cnt !== 4'd0) begin n_fail++; $display("FAIL ar_scnt: got %0d want 0", spec_cnt); end
      n_tests++; if (cmt_cnt !== 4'd0) begin n_fail++; $display("FAIL ar_ccnt: got %0d want 0", cmt_cnt); end
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   initial begin
      test_reset();
      test_push_pop();
      test_overflow();
      test_push_and_pop();
      test_flush();
      test_flush_same_cycle();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
